// File: rtl/usrt_result_tx_if.sv
// Request/response bundle between the result source and the serial result transmitter.
// The master side issues start with the payload; the slave side returns the serial link and status.
interface usrt_result_tx_if;
  localparam int unsigned RES_W = 16;
  localparam int unsigned CMD_W = 4;

  logic             start;
  logic [RES_W-1:0] result;
  logic [CMD_W-1:0] cmd;
  logic             err;
  logic             usrt_clk;
  logic             usrt_tx;
  logic             busy;
  logic             done;

  modport master (
    output start, result, cmd, err,
    input  usrt_clk, usrt_tx, busy, done
  );

  modport slave (
    input  start, result, cmd, err,
    output usrt_clk, usrt_tx, busy, done
  );
endinterface

// File: rtl/usrt_result_tx.sv
// Serial result transmitter: latches result/cmd/err on start and sends a 5-byte frame
// (header, flags+cmd, result hi, result lo, xor checksum) MSB first over a clock+data link.
module usrt_result_tx #(
  parameter int unsigned CLK_DIV = 8,
  parameter logic [7:0]  HEADER  = 8'hA5
) (
  input  logic             clk16M,
  input  logic             rst,
  usrt_result_tx_if.slave  bus
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BYTE_W = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t               state;
  logic [15:0]          lat_result;
  logic [3:0]           lat_cmd;
  logic                 lat_err;
  logic [4*BYTE_W-1:0]  pend;
  logic [BYTE_W-1:0]    sh;
  logic [DIV_W-1:0]     div;
  logic [2:0]           bit_cnt;
  logic [2:0]           byte_cnt;
  logic                 gap_half;
  logic                 uclk;
  logic                 tx;
  logic                 busy;
  logic                 done;

  logic [BYTE_W-1:0]    b1_c;
  logic [BYTE_W-1:0]    b2_c;
  logic [BYTE_W-1:0]    b3_c;
  logic [BYTE_W-1:0]    b4_c;
  logic                 tick_c;

  // Frame bytes after the header, built from the latched payload
  assign b1_c   = {lat_err, 3'b000, lat_cmd};
  assign b2_c   = lat_result[15:8];
  assign b3_c   = lat_result[7:0];
  assign b4_c   = HEADER ^ b1_c ^ b2_c ^ b3_c;
  assign tick_c = (div == DIV_LAST);

  assign bus.usrt_clk = uclk;
  assign bus.usrt_tx  = tx;
  assign bus.busy     = busy;
  assign bus.done     = done;

  always_ff @(posedge clk16M or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lat_result <= '0;
      lat_cmd    <= '0;
      lat_err    <= 1'b0;
      pend       <= '0;
      sh         <= '0;
      div        <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      gap_half   <= 1'b0;
      uclk       <= 1'b1;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            lat_result <= bus.result;
            lat_cmd    <= bus.cmd;
            lat_err    <= bus.err;
            state      <= LOAD;
          end
        end

        LOAD: begin
          sh       <= HEADER;
          pend     <= {b1_c, b2_c, b3_c, b4_c};
          div      <= '0;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          busy     <= 1'b1;
          state    <= SHIFT;
        end

        SHIFT: begin
          div <= tick_c ? '0 : div + DIV_W'(1);
          if (tick_c) begin
            uclk <= ~uclk;
            if (uclk) begin
              // Falling edge: present the next bit for a full usrt_clk period
              tx <= sh[BYTE_W-1];
              sh <= {sh[BYTE_W-2:0], 1'b0};
            end else if (bit_cnt == 3'd7) begin
              // Rising edge closing a byte: queue the next one with no gap
              bit_cnt <= '0;
              if (byte_cnt == 3'd4) begin
                gap_half <= 1'b0;
                state    <= GAP;
              end else begin
                sh       <= pend[4*BYTE_W-1 -: BYTE_W];
                pend     <= {pend[3*BYTE_W-1:0], BYTE_W'(0)};
                byte_cnt <= byte_cnt + 3'd1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        GAP: begin
          div <= tick_c ? '0 : div + DIV_W'(1);
          if (tick_c) begin
            // Data returns high where the next falling edge would have been
            if (!gap_half) begin
              tx       <= 1'b1;
              gap_half <= 1'b1;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usrt_result_tx.sv
// Directed bench for usrt_result_tx: decodes frames on usrt_clk rising edges and checks
// timing, busy/done behaviour, ignored starts, mid-frame reset and back-to-back frames.
module tb_usrt_result_tx;

  logic clk16M;
  logic rst_n;
  logic sel;
  int   vectors;
  int   miscompares;

  usrt_result_tx_if b8 ();
  usrt_result_tx_if b2 ();

  usrt_result_tx #(.CLK_DIV(8), .HEADER(8'hA5)) dut8 (.clk16M(clk16M), .rst(rst_n), .bus(b8));
  usrt_result_tx #(.CLK_DIV(2), .HEADER(8'hA5)) dut2 (.clk16M(clk16M), .rst(rst_n), .bus(b2));

  wire m_uclk = sel ? b2.usrt_clk : b8.usrt_clk;
  wire m_tx   = sel ? b2.usrt_tx  : b8.usrt_tx;
  wire m_busy = sel ? b2.busy     : b8.busy;
  wire m_done = sel ? b2.done     : b8.done;

  initial clk16M = 1'b0;
  always #5 clk16M = ~clk16M;

  // Results of the most recent capture
  logic [39:0] f_bits;
  int          f_nbits, f_done_at, f_ndone, f_busy_err, f_first_fall;
  int          f_min_half, f_max_half, f_txrise;
  logic        f_busy0, f_busy1, f_rst_ck, f_rst_tx, f_rst_busy;

  task automatic set_data(input logic [15:0] r, input logic [3:0] c, input logic e);
    b8.result = r; b8.cmd = c; b8.err = e;
    b2.result = r; b2.cmd = c; b2.err = e;
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) b2.start = v; else b8.start = v;
  endtask

  // Starts a frame (unless already requested) and records what the selected DUT emits.
  task automatic capture(input bit s, input bit pre, input int inj_k, input int rst_k,
                         input bit chain, input logic [15:0] r2, input logic [3:0] c2, input logic e2);
    logic ck, tx, prev_ck, prev_tx;
    int   last_toggle;
    sel = s;
    if (!pre) set_start(s, 1'b1);
    @(negedge clk16M);
    f_bits = '0; f_nbits = 0; f_done_at = -1; f_ndone = 0; f_busy_err = 0; f_first_fall = -1;
    f_min_half = 1000000; f_max_half = -1; f_txrise = 0; f_busy0 = 1'bx; f_busy1 = 1'bx;
    prev_ck = 1'b1; prev_tx = 1'b1; last_toggle = -1;
    for (int k = 0; k < 2000; k++) begin
      b8.start = 1'b0; b2.start = 1'b0;
      ck = m_uclk; tx = m_tx;
      if (k == 0) f_busy0 = m_busy;
      if (k == 1) f_busy1 = m_busy;
      if (ck !== prev_ck) begin
        if (last_toggle >= 0) begin
          if (k - last_toggle < f_min_half) f_min_half = k - last_toggle;
          if (k - last_toggle > f_max_half) f_max_half = k - last_toggle;
        end else begin
          f_first_fall = k;
        end
        last_toggle = k;
        if (prev_ck === 1'b0 && ck === 1'b1) begin
          f_bits = {f_bits[38:0], prev_tx};
          f_nbits++;
          if (tx !== prev_tx) f_txrise++;
        end
      end
      if (m_done === 1'b1) begin
        f_ndone++;
        if (f_done_at < 0) f_done_at = k;
        if (m_busy !== 1'b0) f_busy_err++;
      end else if (k >= 1 && f_done_at < 0 && m_busy !== 1'b1) begin
        f_busy_err++;
      end else if (f_done_at >= 0 && m_busy !== 1'b0) begin
        f_busy_err++;
      end
      if (k == inj_k) begin
        b8.result = 16'h5555; b2.result = 16'h5555;
        set_start(s, 1'b1);
      end
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        f_rst_ck = m_uclk; f_rst_tx = m_tx; f_rst_busy = m_busy;
        break;
      end
      if (chain && m_done === 1'b1) begin
        set_data(r2, c2, e2);
        set_start(s, 1'b1);
        break;
      end
      if (f_done_at >= 0 && k >= f_done_at + 4) break;
      prev_ck = ck; prev_tx = tx;
      @(negedge clk16M);
    end
  endtask

  task automatic test_reset;
    int bad;
    b8.start = 1'b0; b2.start = 1'b0;
    set_data(16'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (b8.usrt_clk !== 1'b1) begin miscompares++; $display("FAIL reset_uclk got %b want 1", b8.usrt_clk); end
    vectors++; if (b8.usrt_tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b want 1", b8.usrt_tx); end
    vectors++; if (b8.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", b8.busy); end
    vectors++; if (b8.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", b8.done); end
    repeat (3) @(posedge clk16M);
    @(negedge clk16M);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk16M);
      if (b8.usrt_clk !== 1'b1 || b8.usrt_tx !== 1'b1 || b8.busy !== 1'b0 || b8.done !== 1'b0) bad++;
      if (b2.usrt_clk !== 1'b1 || b2.usrt_tx !== 1'b1 || b2.busy !== 1'b0 || b2.done !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL idle_after_reset bad_cycles got %0d want 0", bad); end
  endtask

  task automatic test_basic_frame;
    set_data(16'h1234, 4'b0001, 1'b0);
    capture(1'b0, 1'b0, -1, -1, 1'b0, 16'h0, 4'h0, 1'b0);
    vectors++; if (f_bits !== 40'hA501123482) begin miscompares++; $display("FAIL basic_frame got %h want a501123482", f_bits); end
    vectors++; if (f_nbits !== 40) begin miscompares++; $display("FAIL basic_nbits got %0d want 40", f_nbits); end
    vectors++; if (f_busy0 !== 1'b0) begin miscompares++; $display("FAIL basic_busy_edgeN got %b want 0", f_busy0); end
    vectors++; if (f_busy1 !== 1'b1) begin miscompares++; $display("FAIL basic_busy_edgeN1 got %b want 1", f_busy1); end
    vectors++; if (f_busy_err !== 0) begin miscompares++; $display("FAIL basic_busy_profile errors got %0d want 0", f_busy_err); end
    vectors++; if (f_done_at !== 657) begin miscompares++; $display("FAIL basic_done_at got %0d want 657", f_done_at); end
    vectors++; if (f_ndone !== 1) begin miscompares++; $display("FAIL basic_done_width got %0d want 1", f_ndone); end
    vectors++; if (f_first_fall !== 9) begin miscompares++; $display("FAIL basic_first_fall got %0d want 9", f_first_fall); end
    vectors++; if (f_min_half !== 8 || f_max_half !== 8) begin miscompares++; $display("FAIL basic_half_period got %0d..%0d want 8..8", f_min_half, f_max_half); end
    vectors++; if (f_txrise !== 0) begin miscompares++; $display("FAIL basic_tx_on_rise got %0d want 0", f_txrise); end
  endtask

  task automatic test_patterns;
    set_data(16'hFFFF, 4'b0100, 1'b0);
    capture(1'b0, 1'b0, -1, -1, 1'b0, 16'h0, 4'h0, 1'b0);
    vectors++; if (f_bits !== 40'hA504FFFFA1) begin miscompares++; $display("FAIL mul_frame got %h want a504ffffa1", f_bits); end
    vectors++; if (f_done_at !== 657) begin miscompares++; $display("FAIL mul_done_at got %0d want 657", f_done_at); end
    set_data(16'h0000, 4'b1000, 1'b1);
    capture(1'b0, 1'b0, -1, -1, 1'b0, 16'h0, 4'h0, 1'b0);
    vectors++; if (f_bits !== 40'hA58800002D) begin miscompares++; $display("FAIL err_frame got %h want a58800002d", f_bits); end
    vectors++; if (f_busy_err !== 0) begin miscompares++; $display("FAIL err_busy_profile errors got %0d want 0", f_busy_err); end
  endtask

  task automatic test_start_while_busy;
    int bad;
    set_data(16'h1234, 4'b0001, 1'b0);
    capture(1'b0, 1'b0, 280, -1, 1'b0, 16'h0, 4'h0, 1'b0);
    vectors++; if (f_bits !== 40'hA501123482) begin miscompares++; $display("FAIL ignore_frame got %h want a501123482", f_bits); end
    vectors++; if (f_ndone !== 1) begin miscompares++; $display("FAIL ignore_done_count got %0d want 1", f_ndone); end
    vectors++; if (f_done_at !== 657) begin miscompares++; $display("FAIL ignore_done_at got %0d want 657", f_done_at); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk16M);
      if (b8.busy !== 1'b0 || b8.done !== 1'b0 || b8.usrt_clk !== 1'b1) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL ignore_no_second_frame bad_cycles got %0d want 0", bad); end
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    set_data(16'h1234, 4'b0001, 1'b0);
    capture(1'b0, 1'b0, -1, 460, 1'b0, 16'h0, 4'h0, 1'b0);
    vectors++; if (f_rst_ck !== 1'b1) begin miscompares++; $display("FAIL midrst_uclk got %b want 1", f_rst_ck); end
    vectors++; if (f_rst_tx !== 1'b1) begin miscompares++; $display("FAIL midrst_tx got %b want 1", f_rst_tx); end
    vectors++; if (f_rst_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", f_rst_busy); end
    repeat (3) @(negedge clk16M);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk16M);
      if (b8.usrt_clk !== 1'b1 || b8.usrt_tx !== 1'b1 || b8.busy !== 1'b0 || b8.done !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL midrst_no_resume bad_cycles got %0d want 0", bad); end
    set_data(16'h0042, 4'b0010, 1'b0);
    capture(1'b0, 1'b0, -1, -1, 1'b0, 16'h0, 4'h0, 1'b0);
    vectors++; if (f_bits !== 40'hA5020042E5) begin miscompares++; $display("FAIL midrst_new_frame got %h want a5020042e5", f_bits); end
    vectors++; if (f_done_at !== 657) begin miscompares++; $display("FAIL midrst_done_at got %0d want 657", f_done_at); end
  endtask

  task automatic test_back_to_back;
    set_data(16'h00FF, 4'b0001, 1'b0);
    capture(1'b1, 1'b0, -1, -1, 1'b1, 16'hABCD, 4'b1000, 1'b1);
    vectors++; if (f_bits !== 40'hA50100FF5B) begin miscompares++; $display("FAIL b2b_first_frame got %h want a50100ff5b", f_bits); end
    vectors++; if (f_done_at !== 165) begin miscompares++; $display("FAIL b2b_first_done_at got %0d want 165", f_done_at); end
    vectors++; if (f_first_fall !== 3) begin miscompares++; $display("FAIL b2b_first_fall got %0d want 3", f_first_fall); end
    vectors++; if (f_min_half !== 2 || f_max_half !== 2) begin miscompares++; $display("FAIL b2b_half_period got %0d..%0d want 2..2", f_min_half, f_max_half); end
    capture(1'b1, 1'b1, -1, -1, 1'b0, 16'h0, 4'h0, 1'b0);
    vectors++; if (f_bits !== 40'hA588ABCD4B) begin miscompares++; $display("FAIL b2b_second_frame got %h want a588abcd4b", f_bits); end
    vectors++; if (f_done_at !== 165) begin miscompares++; $display("FAIL b2b_second_done_at got %0d want 165", f_done_at); end
    vectors++; if (f_ndone !== 1) begin miscompares++; $display("FAIL b2b_second_done_width got %0d want 1", f_ndone); end
    vectors++; if (f_busy1 !== 1'b1 || f_busy_err !== 0) begin miscompares++; $display("FAIL b2b_second_busy got busy1=%b errors=%0d want 1/0", f_busy1, f_busy_err); end
    vectors++; if (f_min_half !== 2 || f_max_half !== 2) begin miscompares++; $display("FAIL b2b_second_half got %0d..%0d want 2..2", f_min_half, f_max_half); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sel         = 1'b0;
    test_reset();
    test_basic_frame();
    test_patterns();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usrt_result_tx.md
Name: usrt_result_tx

Overview:
Serial result transmitter downstream of the operation multiplexer and error logic. On a start pulse it latches the 16-bit binary result, the 4-bit command code and the error flag. It then sends a fixed 5-byte frame back to the host over a synchronous serial link (clock plus data) that mirrors the USRT receive format. The host can then read results without looking at the 7-segment display.

Parameters:
CLK_DIV, 8, half-period of usrt_clk in clk16M cycles (8 -> 1 MHz); legal range 2..255
HEADER, 8'hA5, first byte of every frame
bits, 16, result width; fixed at 16 (frame carries exactly 2 result bytes)

Ports:
clk16M  in  1  system clock, rising-edge
rst  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled on rising clk16M
result  in  16  binary result from the operation multiplexer
cmd  in  4  one-hot command code (0001 add, 0010 sub, 0100 mul, 1000 div, 0000 none)
err  in  1  error flag from the error logic
usrt_clk  out  1  serial clock to host; idles high
usrt_tx  out  1  serial data, MSB first; idles high
busy  out  1  high while a frame is in progress
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; usrt_clk=1, usrt_tx=1, busy=0, done=0; divider, bit and byte counters and shift register cleared. Effective immediately, including mid-frame. The frame is abandoned and nothing resumes after release.
- Frame layout, bytes in order:
  - B0 = HEADER
  - B1 = {err, 3'b000, cmd}
  - B2 = result[15:8]
  - B3 = result[7:0]
  - B4 = B0^B1^B2^B3
  - All bytes sent MSB first, back to back; 40 bits total.
- States: IDLE -> LOAD -> SHIFT -> GAP -> IDLE.
  - IDLE: on start=1 at edge N, latch result/cmd/err.
  - LOAD: at edge N+1, compute B1..B4, load B0 into shift register, busy=1, divider=0.
  - SHIFT: divider counts 0..CLK_DIV-1; usrt_clk toggles at each terminal count.
    - First falling edge of usrt_clk at edge N+1+CLK_DIV.
    - Each falling edge drives the next bit onto usrt_tx. The bit is held for a full usrt_clk period, so the host samples it on the following rising edge.
    - After 8 rising edges, the next byte loads without a gap.
    - The 40th rising edge is at edge N+1+80*CLK_DIV.
  - GAP: usrt_clk held 1, usrt_tx=1 for 2*CLK_DIV cycles.
  - Exit to IDLE: at edge N+1+82*CLK_DIV, done=1 for exactly one cycle and busy=0 in that same cycle.
- Latency (CLK_DIV=8): busy rises 1 cycle after start; done 657 cycles after start edge.
- start while busy=1: ignored, no queueing.
- start in the cycle done=1: state is already IDLE, so the start is accepted and the new frame begins normally.
- result/cmd/err changes after latch: no effect on the frame in flight.
- usrt_tx changes only on usrt_clk falling edges, or when returning to idle high in GAP. It never changes coincident with a rising edge.
- usrt_clk is glitch-free and registered; duty cycle is exactly 50% during SHIFT.

Test Plan:
1. rst=0 for 3 cycles, then release, no start -> usrt_clk=1, usrt_tx=1, busy=0, done=0 continuously for 1000 cycles.
2. start with result=16'h1234, cmd=4'b0001, err=0, CLK_DIV=8 -> bits sampled on usrt_clk rising edges decode A5 01 12 34 82; busy high from edge N+1; done single pulse at N+657.
3. start with result=16'hFFFF, cmd=4'b0100, err=0 -> frame A5 04 FF FF A1. Then start with cmd=4'b1000, err=1, result=16'h0000 -> frame A5 88 00 00 2D.
4. During frame from test 2, pulse start at byte 2 and change result to 16'h5555 -> frame unchanged (A5 01 12 34 82); exactly one done.
5. Assert rst mid-byte 3 -> usrt_clk and usrt_tx go to 1 and busy to 0 without waiting for clk16M. After release, a new start with result=16'h0042, cmd=4'b0010 -> clean frame A5 02 00 42 E5.
6. CLK_DIV=2, start asserted in the same cycle as done of a previous frame -> second frame accepted; each usrt_clk half-period is exactly 2 cycles; done 165 cycles after the start edge.
